// File: rtl/reservation_station.sv
// Reservation station for ALU-class instructions: holds dispatched ops, snoops the ALU and LSB CDBs
// for pending operands, and issues the lowest-index ready entry per cycle through registered outputs.

module rs_entry #(
  parameter int ROB_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             clear,
  input  logic             load,
  input  logic             issue,
  input  logic [5:0]       d_op,
  input  logic [31:0]      d_vj,
  input  logic [31:0]      d_vk,
  input  logic [ROB_W-1:0] d_qj,
  input  logic [ROB_W-1:0] d_qk,
  input  logic             d_qj_busy,
  input  logic             d_qk_busy,
  input  logic [31:0]      d_imm,
  input  logic [31:0]      d_pc,
  input  logic [ROB_W-1:0] d_rob,
  input  logic             alu_cdb_valid,
  input  logic [ROB_W-1:0] alu_cdb_rob,
  input  logic [31:0]      alu_cdb_val,
  input  logic             lsb_cdb_valid,
  input  logic [ROB_W-1:0] lsb_cdb_rob,
  input  logic [31:0]      lsb_cdb_val,
  output logic             busy,
  output logic             ready,
  output logic [5:0]       op,
  output logic [31:0]      vj,
  output logic [31:0]      vk,
  output logic [31:0]      imm,
  output logic [31:0]      pc,
  output logic [ROB_W-1:0] rob
);
  logic [ROB_W-1:0] qj, qk;
  logic             qj_busy, qk_busy;

  assign ready = busy & ~qj_busy & ~qk_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= 1'b0; op <= '0; vj <= '0; vk <= '0; imm <= '0; pc <= '0; rob <= '0;
      qj <= '0; qk <= '0; qj_busy <= 1'b0; qk_busy <= 1'b0;
    end else if (rdy) begin
      if (clear) begin
        busy <= 1'b0;
      end else if (load) begin
        busy <= 1'b1; op <= d_op; vj <= d_vj; vk <= d_vk; imm <= d_imm; pc <= d_pc; rob <= d_rob;
        qj <= d_qj; qk <= d_qk; qj_busy <= d_qj_busy; qk_busy <= d_qk_busy;
      end else begin
        if (issue) busy <= 1'b0;
        // ALU CDB takes precedence if both buses carry the same tag
        if (busy && qj_busy) begin
          if (alu_cdb_valid && alu_cdb_rob == qj) begin
            vj <= alu_cdb_val; qj_busy <= 1'b0;
          end else if (lsb_cdb_valid && lsb_cdb_rob == qj) begin
            vj <= lsb_cdb_val; qj_busy <= 1'b0;
          end
        end
        if (busy && qk_busy) begin
          if (alu_cdb_valid && alu_cdb_rob == qk) begin
            vk <= alu_cdb_val; qk_busy <= 1'b0;
          end else if (lsb_cdb_valid && lsb_cdb_rob == qk) begin
            vk <= lsb_cdb_val; qk_busy <= 1'b0;
          end
        end
      end
    end
  end
endmodule

module reservation_station #(
  parameter int RS_SIZE = 16,
  parameter int ROB_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             clear,
  input  logic             disp_valid,
  input  logic [5:0]       disp_opcode,
  input  logic [31:0]      disp_vj,
  input  logic [31:0]      disp_vk,
  input  logic [ROB_W-1:0] disp_qj,
  input  logic [ROB_W-1:0] disp_qk,
  input  logic             disp_qj_busy,
  input  logic             disp_qk_busy,
  input  logic [31:0]      disp_imm,
  input  logic [31:0]      disp_pc,
  input  logic [ROB_W-1:0] disp_rob,
  output logic             full,
  input  logic             alu_cdb_valid,
  input  logic [ROB_W-1:0] alu_cdb_rob,
  input  logic [31:0]      alu_cdb_val,
  input  logic             lsb_cdb_valid,
  input  logic [ROB_W-1:0] lsb_cdb_rob,
  input  logic [31:0]      lsb_cdb_val,
  output logic             RS_sgn,
  output logic [5:0]       RS_opcode,
  output logic [31:0]      lhs,
  output logic [31:0]      rhs,
  output logic [31:0]      imm,
  output logic [31:0]      pc,
  output logic [ROB_W-1:0] ROB_entry
);
  localparam int IDX_W = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0]            e_busy, e_ready, load, issue;
  logic [RS_SIZE-1:0][5:0]       e_op;
  logic [RS_SIZE-1:0][31:0]      e_vj, e_vk, e_imm, e_pc;
  logic [RS_SIZE-1:0][ROB_W-1:0] e_rob;
  logic [IDX_W-1:0]              free_idx, iss_idx;
  logic                          iss_found, do_disp, do_iss;
  logic                          alu_hit_j, lsb_hit_j, alu_hit_k, lsb_hit_k;
  logic [31:0]                   byp_vj, byp_vk;

  assign full = &e_busy;

  // Both selects look only at registered state, so a slot freed by issue is not reused this cycle
  always_comb begin
    free_idx  = '0;
    iss_idx   = '0;
    iss_found = 1'b0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!e_busy[i]) free_idx = IDX_W'(i);
      if (e_ready[i]) begin
        iss_idx   = IDX_W'(i);
        iss_found = 1'b1;
      end
    end
  end

  assign do_disp = rdy & ~clear & disp_valid & ~full;
  assign do_iss  = rdy & ~clear & iss_found;

  assign alu_hit_j = alu_cdb_valid && alu_cdb_rob == disp_qj;
  assign lsb_hit_j = lsb_cdb_valid && lsb_cdb_rob == disp_qj;
  assign alu_hit_k = alu_cdb_valid && alu_cdb_rob == disp_qk;
  assign lsb_hit_k = lsb_cdb_valid && lsb_cdb_rob == disp_qk;

  assign byp_vj = (disp_qj_busy && alu_hit_j) ? alu_cdb_val :
                  (disp_qj_busy && lsb_hit_j) ? lsb_cdb_val : disp_vj;
  assign byp_vk = (disp_qk_busy && alu_hit_k) ? alu_cdb_val :
                  (disp_qk_busy && lsb_hit_k) ? lsb_cdb_val : disp_vk;

  for (genvar g = 0; g < RS_SIZE; g++) begin : g_ent
    assign load[g]  = do_disp && free_idx == IDX_W'(g);
    assign issue[g] = do_iss && iss_idx == IDX_W'(g);

    rs_entry #(.ROB_W(ROB_W)) u_ent (
      .clk, .rst, .rdy, .clear,
      .load(load[g]), .issue(issue[g]),
      .d_op(disp_opcode), .d_vj(byp_vj), .d_vk(byp_vk), .d_qj(disp_qj), .d_qk(disp_qk),
      .d_qj_busy(disp_qj_busy & ~alu_hit_j & ~lsb_hit_j),
      .d_qk_busy(disp_qk_busy & ~alu_hit_k & ~lsb_hit_k),
      .d_imm(disp_imm), .d_pc(disp_pc), .d_rob(disp_rob),
      .alu_cdb_valid, .alu_cdb_rob, .alu_cdb_val,
      .lsb_cdb_valid, .lsb_cdb_rob, .lsb_cdb_val,
      .busy(e_busy[g]), .ready(e_ready[g]), .op(e_op[g]), .vj(e_vj[g]), .vk(e_vk[g]),
      .imm(e_imm[g]), .pc(e_pc[g]), .rob(e_rob[g])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RS_sgn <= 1'b0; RS_opcode <= '0; lhs <= '0; rhs <= '0; imm <= '0; pc <= '0; ROB_entry <= '0;
    end else if (do_iss) begin
      RS_sgn    <= 1'b1;
      RS_opcode <= e_op[iss_idx];
      lhs       <= e_vj[iss_idx];
      rhs       <= e_vk[iss_idx];
      imm       <= e_imm[iss_idx];
      pc        <= e_pc[iss_idx];
      ROB_entry <= e_rob[iss_idx];
    end else begin
      RS_sgn <= 1'b0;
    end
  end
endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: directed scenarios with literal expectations plus a randomized run,
// every cycle compared against an entry-list model of the station.
module tb_reservation_station;
  localparam logic [5:0] ADD = 6'd1;

  logic        clk = 1'b0, rst = 1'b0, rdy = 1'b1, clear = 1'b0;
  logic        disp_valid = 1'b0, disp_qj_busy = 1'b0, disp_qk_busy = 1'b0;
  logic [5:0]  disp_opcode = '0;
  logic [31:0] disp_vj = '0, disp_vk = '0, disp_imm = '0, disp_pc = '0;
  logic [3:0]  disp_qj = '0, disp_qk = '0, disp_rob = '0;
  logic        alu_cdb_valid = 1'b0, lsb_cdb_valid = 1'b0;
  logic [3:0]  alu_cdb_rob = '0, lsb_cdb_rob = '0;
  logic [31:0] alu_cdb_val = '0, lsb_cdb_val = '0;
  logic        full, RS_sgn;
  logic [5:0]  RS_opcode;
  logic [31:0] lhs, rhs, imm, pc;
  logic [3:0]  ROB_entry;

  int n_cmp = 0, n_err = 0;

  reservation_station #(.RS_SIZE(16), .ROB_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .disp_valid(disp_valid), .disp_opcode(disp_opcode), .disp_vj(disp_vj), .disp_vk(disp_vk),
    .disp_qj(disp_qj), .disp_qk(disp_qk), .disp_qj_busy(disp_qj_busy), .disp_qk_busy(disp_qk_busy),
    .disp_imm(disp_imm), .disp_pc(disp_pc), .disp_rob(disp_rob), .full(full),
    .alu_cdb_valid(alu_cdb_valid), .alu_cdb_rob(alu_cdb_rob), .alu_cdb_val(alu_cdb_val),
    .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_rob(lsb_cdb_rob), .lsb_cdb_val(lsb_cdb_val),
    .RS_sgn(RS_sgn), .RS_opcode(RS_opcode), .lhs(lhs), .rhs(rhs), .imm(imm), .pc(pc),
    .ROB_entry(ROB_entry)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          busy, qjb, qkb;
    logic [5:0]  op;
    logic [31:0] vj, vk, imm, pc;
    logic [3:0]  qj, qk, rob;
  } ent_t;

  ent_t        m[16];
  bit          m_sgn;
  logic [5:0]  m_op;
  logic [31:0] m_lhs, m_rhs, m_imm, m_pc;
  logic [3:0]  m_rob;

  function automatic void model_reset();
    foreach (m[i]) m[i].busy = 0;
    m_sgn = 0; m_op = '0; m_lhs = '0; m_rhs = '0; m_imm = '0; m_pc = '0; m_rob = '0;
  endfunction

  // Resolve a pending operand against the two buses (ALU first); returns 1 if captured.
  function automatic bit snoop(input logic [3:0] tag, output logic [31:0] v);
    v = '0;
    if (alu_cdb_valid && alu_cdb_rob == tag) begin v = alu_cdb_val; return 1; end
    if (lsb_cdb_valid && lsb_cdb_rob == tag) begin v = lsb_cdb_val; return 1; end
    return 0;
  endfunction

  // What the station must do at the coming edge, given current inputs and contents.
  function automatic void model_step();
    int sel = -1, fr = -1, cnt = 0;
    logic [31:0] v;
    if (!rdy) begin m_sgn = 0; return; end
    if (clear) begin foreach (m[i]) m[i].busy = 0; m_sgn = 0; return; end
    for (int i = 0; i < 16; i++) begin
      if (m[i].busy) cnt++;
      else if (fr < 0) fr = i;
      if (sel < 0 && m[i].busy && !m[i].qjb && !m[i].qkb) sel = i;
    end
    for (int i = 0; i < 16; i++) if (m[i].busy) begin
      if (m[i].qjb && snoop(m[i].qj, v)) begin m[i].vj = v; m[i].qjb = 0; end
      if (m[i].qkb && snoop(m[i].qk, v)) begin m[i].vk = v; m[i].qkb = 0; end
    end
    m_sgn = (sel >= 0);
    if (sel >= 0) begin
      m_op = m[sel].op; m_lhs = m[sel].vj; m_rhs = m[sel].vk;
      m_imm = m[sel].imm; m_pc = m[sel].pc; m_rob = m[sel].rob;
      m[sel].busy = 0;
    end
    if (disp_valid && cnt < 16) begin
      m[fr].busy = 1; m[fr].op = disp_opcode; m[fr].imm = disp_imm; m[fr].pc = disp_pc;
      m[fr].rob = disp_rob; m[fr].qj = disp_qj; m[fr].qk = disp_qk;
      m[fr].vj = disp_vj; m[fr].qjb = disp_qj_busy;
      m[fr].vk = disp_vk; m[fr].qkb = disp_qk_busy;
      if (disp_qj_busy && snoop(disp_qj, v)) begin m[fr].vj = v; m[fr].qjb = 0; end
      if (disp_qk_busy && snoop(disp_qk, v)) begin m[fr].vk = v; m[fr].qkb = 0; end
    end
  endfunction

  function automatic bit m_full();
    int cnt = 0;
    foreach (m[i]) if (m[i].busy) cnt++;
    return cnt == 16;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("RS_sgn", {31'd0, RS_sgn}, {31'd0, m_sgn});
    chk("full", {31'd0, full}, {31'd0, m_full()});
    chk("RS_opcode", {26'd0, RS_opcode}, {26'd0, m_op});
    chk("lhs", lhs, m_lhs);
    chk("rhs", rhs, m_rhs);
    chk("imm", imm, m_imm);
    chk("pc", pc, m_pc);
    chk("ROB_entry", {28'd0, ROB_entry}, {28'd0, m_rob});
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk); #1;
    compare_all();
  endtask

  task automatic idle();
    disp_valid = 0; disp_qj_busy = 0; disp_qk_busy = 0; clear = 0; rdy = 1;
    alu_cdb_valid = 0; lsb_cdb_valid = 0;
  endtask

  task automatic disp(input logic [31:0] vj, vk, input bit jb, input logic [3:0] qj, input logic [3:0] rob);
    disp_valid = 1; disp_opcode = ADD; disp_vj = vj; disp_vk = vk; disp_qj_busy = jb; disp_qj = qj;
    disp_qk_busy = 0; disp_qk = 4'd0; disp_rob = rob; disp_imm = 32'h100 + rob; disp_pc = 32'h1000 + 4 * rob;
  endtask

  task automatic flush();
    idle(); clear = 1; cyc(); idle(); cyc();
  endtask

  initial begin
    model_reset();
    #1;
    chk("reset_sgn", {31'd0, RS_sgn}, 32'd0);
    chk("reset_full", {31'd0, full}, 32'd0);
    #13 rst = 1;
    @(negedge clk);
    compare_all();

    // Ready ADD 3+4 issues one cycle after dispatch
    disp(32'd3, 32'd4, 0, 4'd0, 4'd2); cyc();
    idle(); cyc();
    chk("t2_sgn", {31'd0, RS_sgn}, 32'd1);
    chk("t2_op", {26'd0, RS_opcode}, {26'd0, ADD});
    chk("t2_lhs", lhs, 32'd3);
    chk("t2_rhs", rhs, 32'd4);
    chk("t2_rob", {28'd0, ROB_entry}, 32'd2);
    chk("t2_sum", lhs + rhs, 32'd7);
    cyc();
    chk("t2_strobe_once", {31'd0, RS_sgn}, 32'd0);

    // Wakeup two cycles after dispatch
    disp(32'd0, 32'd1, 1, 4'd5, 4'd3); cyc();
    idle(); cyc();
    alu_cdb_valid = 1; alu_cdb_rob = 4'd5; alu_cdb_val = 32'h10; cyc();
    chk("t3_no_early", {31'd0, RS_sgn}, 32'd0);
    idle(); cyc();
    chk("t3_sgn", {31'd0, RS_sgn}, 32'd1);
    chk("t3_lhs", lhs, 32'h10);
    // Same-cycle bypass
    disp(32'd0, 32'd1, 1, 4'd5, 4'd4);
    alu_cdb_valid = 1; alu_cdb_rob = 4'd5; alu_cdb_val = 32'h20; cyc();
    idle(); cyc();
    chk("t3b_sgn", {31'd0, RS_sgn}, 32'd1);
    chk("t3b_lhs", lhs, 32'h20);
    cyc();

    // Fill 16 pending entries; 17th dispatch dropped
    for (int i = 0; i < 16; i++) begin
      disp(32'd0, 32'd9, 1, (i == 0) ? 4'd7 : 4'd9, 4'(i)); cyc();
    end
    chk("t4_full", {31'd0, full}, 32'd1);
    disp(32'd0, 32'd9, 0, 4'd0, 4'd15); cyc();
    chk("t4_drop_nosgn", {31'd0, RS_sgn}, 32'd0);
    idle(); alu_cdb_valid = 1; alu_cdb_rob = 4'd7; alu_cdb_val = 32'h77; cyc();
    chk("t4_still_full", {31'd0, full}, 32'd1);
    idle(); cyc();
    chk("t4_sgn", {31'd0, RS_sgn}, 32'd1);
    chk("t4_rob", {28'd0, ROB_entry}, 32'd0);
    chk("t4_lhs", lhs, 32'h77);
    chk("t4_full_drop", {31'd0, full}, 32'd0);
    cyc();
    chk("t4_dropped", {31'd0, RS_sgn}, 32'd0);
    flush();

    // Entries 1 and 3 woken together: lower index first
    disp(32'd0, 32'd0, 1, 4'd7, 4'd10); cyc();
    disp(32'd0, 32'd0, 1, 4'd8, 4'd11); cyc();
    disp(32'd0, 32'd0, 1, 4'd7, 4'd12); cyc();
    disp(32'd0, 32'd0, 1, 4'd8, 4'd13); cyc();
    idle(); lsb_cdb_valid = 1; lsb_cdb_rob = 4'd8; lsb_cdb_val = 32'h88; cyc();
    idle(); cyc();
    chk("t5_first", {28'd0, ROB_entry}, 32'd11);
    cyc();
    chk("t5_second_sgn", {31'd0, RS_sgn}, 32'd1);
    chk("t5_second", {28'd0, ROB_entry}, 32'd13);

    // Clear with 4 busy and a simultaneous dispatch
    disp(32'd0, 32'd0, 1, 4'd7, 4'd1); cyc();
    disp(32'd0, 32'd0, 1, 4'd7, 4'd2); cyc();
    disp(32'd5, 32'd6, 0, 4'd0, 4'd6); clear = 1; cyc();
    idle(); alu_cdb_valid = 1; alu_cdb_rob = 4'd7; cyc();
    idle();
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t6_clear_nosgn", {31'd0, RS_sgn}, 32'd0);
    end

    // rdy low for 3 cycles holds a ready entry
    disp(32'd5, 32'd6, 0, 4'd0, 4'd9); cyc();
    idle(); rdy = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t6_frozen", {31'd0, RS_sgn}, 32'd0);
    end
    rdy = 1; cyc();
    chk("t6_resume", {31'd0, RS_sgn}, 32'd1);
    chk("t6_resume_rob", {28'd0, ROB_entry}, 32'd9);

    // Async reset mid-run with 5 busy entries
    for (int i = 0; i < 5; i++) begin
      disp(32'd0, 32'd0, 1, 4'd3, 4'(i)); cyc();
    end
    idle(); #2 rst = 0; #1;
    chk("t1_full", {31'd0, full}, 32'd0);
    chk("t1_sgn", {31'd0, RS_sgn}, 32'd0);
    chk("t1_lhs", lhs, 32'd0);
    chk("t1_rob", {28'd0, ROB_entry}, 32'd0);
    model_reset();
    @(negedge clk); rst = 1;
    alu_cdb_valid = 1; alu_cdb_rob = 4'd3; cyc();
    idle(); cyc();
    chk("t1_empty", {31'd0, RS_sgn}, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      rdy           = ($urandom_range(0, 9) != 0);
      clear         = ($urandom_range(0, 79) == 0);
      disp_valid    = $urandom_range(0, 1);
      disp_opcode   = 6'($urandom);
      disp_vj       = $urandom; disp_vk = $urandom; disp_imm = $urandom; disp_pc = $urandom;
      disp_qj       = 4'($urandom_range(0, 7)); disp_qk = 4'($urandom_range(0, 7));
      disp_qj_busy  = $urandom_range(0, 1); disp_qk_busy = $urandom_range(0, 1);
      disp_rob      = 4'($urandom);
      alu_cdb_valid = $urandom_range(0, 1); alu_cdb_rob = 4'($urandom_range(0, 7)); alu_cdb_val = $urandom;
      lsb_cdb_valid = $urandom_range(0, 1); lsb_cdb_rob = 4'($urandom_range(0, 7)); lsb_cdb_val = $urandom;
      cyc();
    end
    idle(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
